// File: rtl/rvc_compressor.sv
// Streaming RV32I-to-RV32C compressor: re-encodes a supported subset as 16-bit
// instructions and packs halfwords little-endian into 32-bit memory words.
module rvc_compressor #(
    parameter bit ENABLE_COMPRESS = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_last,
    output logic             flush_done,
    output logic [CNT_W-1:0] compressed_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [15:0] C_NOP      = 16'h0001;

    state_t           state_q, state_d;
    logic [31:0]      out_word_q, out_word_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_i, imm_s;
    logic        rd_p, rs1_p, rs2_p;
    logic        imm_i_small, lw_off_ok, sw_off_ok;
    logic        is_c;
    logic [15:0] c_half;
    logic        out_free, accept;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign f7     = in_instr[31:25];
    assign imm_i  = in_instr[31:20];
    assign imm_s  = {in_instr[31:25], in_instr[11:7]};

    // Compressed register fields can only name x8..x15.
    assign rd_p  = (rd[4:3] == 2'b01);
    assign rs1_p = (rs1[4:3] == 2'b01);
    assign rs2_p = (rs2[4:3] == 2'b01);

    assign imm_i_small = (imm_i[11:5] == {7{imm_i[5]}});
    assign lw_off_ok   = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
    assign sw_off_ok   = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);

    always_comb begin
        is_c   = 1'b0;
        c_half = 16'h0000;
        if (ENABLE_COMPRESS) begin
            case (opcode)
                OPC_OP: begin
                    if (f3 == 3'b000 && f7 == 7'b0000000 && rs1 == 5'd0
                        && rd != 5'd0 && rs2 != 5'd0) begin
                        is_c   = 1'b1;
                        c_half = {3'b100, 1'b0, rd, rs2, 2'b10};
                    end else if (f3 == 3'b000 && f7 == 7'b0000000 && rd == rs1
                                 && rd != 5'd0 && rs2 != 5'd0) begin
                        is_c   = 1'b1;
                        c_half = {3'b100, 1'b1, rd, rs2, 2'b10};
                    end else if (rd == rs1 && rd_p && rs2_p) begin
                        if (f3 == 3'b000 && f7 == 7'b0100000) begin
                            is_c   = 1'b1;
                            c_half = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
                        end else if (f7 == 7'b0000000 && f3 == 3'b100) begin
                            is_c   = 1'b1;
                            c_half = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
                        end else if (f7 == 7'b0000000 && f3 == 3'b110) begin
                            is_c   = 1'b1;
                            c_half = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
                        end else if (f7 == 7'b0000000 && f3 == 3'b111) begin
                            is_c   = 1'b1;
                            c_half = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
                        end
                    end
                end
                OPC_OP_IMM: begin
                    if (f3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 && imm_i_small) begin
                        is_c   = 1'b1;
                        c_half = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                    end else if (f3 == 3'b000 && rd == rs1 && rd != 5'd0
                                 && imm_i != 12'd0 && imm_i_small) begin
                        is_c   = 1'b1;
                        c_half = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                    end else if (f3 == 3'b001 && f7 == 7'b0000000 && rd == rs1
                                 && rd != 5'd0 && rs2 != 5'd0) begin
                        is_c   = 1'b1;
                        c_half = {3'b000, 1'b0, rd, rs2, 2'b10};
                    end
                end
                OPC_LOAD: begin
                    if (f3 == 3'b010 && rd_p && rs1_p && lw_off_ok) begin
                        is_c   = 1'b1;
                        c_half = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6],
                                  rd[2:0], 2'b00};
                    end
                end
                OPC_STORE: begin
                    if (f3 == 3'b010 && rs1_p && rs2_p && sw_off_ok) begin
                        is_c   = 1'b1;
                        c_half = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6],
                                  rs2[2:0], 2'b00};
                    end
                end
                default: begin
                    is_c   = 1'b0;
                    c_half = 16'h0000;
                end
            endcase
        end
    end

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ST_RUN) && !flush && out_free;
    assign accept   = in_valid && in_ready;

    // A 32-bit instruction arriving behind a pending halfword straddles two words.
    always_comb begin
        state_d      = state_q;
        out_word_d   = out_word_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        count_d      = count_q;
        flush_done   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (accept) begin
                    if (is_c) begin
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_d = count_q + 1'b1;
                        end
                        if (pend_valid_q) begin
                            out_word_d   = {c_half, pend_q};
                            out_valid_d  = 1'b1;
                            out_last_d   = 1'b0;
                            pend_valid_d = 1'b0;
                        end else begin
                            pend_d       = c_half;
                            pend_valid_d = 1'b1;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        if (pend_valid_q) begin
                            out_word_d = {in_instr[15:0], pend_q};
                            pend_d     = in_instr[31:16];
                        end else begin
                            out_word_d = in_instr;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    if (pend_valid_q) begin
                        out_word_d   = {C_NOP, pend_q};
                        out_valid_d  = 1'b1;
                        out_last_d   = 1'b1;
                        pend_valid_d = 1'b0;
                    end
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_free) begin
                    flush_done = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            out_word_q   <= 32'h0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            pend_q       <= 16'h0;
            pend_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            out_word_q   <= out_word_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            count_q      <= count_d;
        end
    end

    assign out_word         = out_word_q;
    assign out_valid        = out_valid_q;
    assign out_last         = out_last_q;
    assign compressed_count = count_q;

endmodule

// File: doc/rvc_compressor.md
Name: rvc_compressor

Overview:
- Streaming RV32I-to-RV32C compressor and packer. It is the write-side counterpart of the fetch-side decompressor.
- Accepts one 32-bit instruction per handshake and re-encodes it as a 16-bit RVC instruction when the supported subset allows; otherwise it passes the instruction through.
- Packs the resulting halfwords little-endian into 32-bit memory words on a valid/ready output stream.
- Sits between the program loader (UART/boot stream) and instruction-memory write port. Its output must decode back to the original program through the decompressor.

Parameters:
- ENABLE_COMPRESS, 1, 0 = never compress (pure passthrough packer); 1 = compress the supported subset.
- CNT_W, 16, width of compressed_count.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_instr valid
- in_ready  output  1  block accepts in_instr this cycle
- in_instr  input  32  uncompressed RV32I instruction
- flush  input  1  single-cycle pulse: emit any pending halfword and signal completion
- out_valid  output  1  out_word valid
- out_ready  input  1  sink accepts out_word
- out_word  output  32  packed memory word; bits [15:0] hold the earlier halfword
- out_last  output  1  qualifies out_word as the flush word
- flush_done  output  1  one-cycle pulse when flush has fully drained
- compressed_count  output  CNT_W  saturating count of instructions emitted compressed

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_word=0, out_last=0, flush_done=0, compressed_count=0.
  - pend_valid=0, state=RUN.
  - Reset mid-stream drops the pending halfword and any unaccepted output word.
- Output register:
  - A single registered output stage; out_word, out_valid and out_last are held stable while out_valid && !out_ready.
  - Define "out_free" = !out_valid || out_ready.
- Input acceptance: in_ready = (state==RUN) && !flush && out_free. An accept takes effect on the same clock edge.
- Compression check: combinational, evaluated on in_instr. Fields: rd=[11:7], rs1=[19:15], rs2=[24:20], f3=[14:12], f7=[31:25]. "Primed" means the register is in x8..x15 (r' = r[2:0]).
  - C.MV: ADD, rs1==0, rd!=0, rs2!=0 -> {100,0,rd,rs2,10}.
  - C.ADD: ADD, rd==rs1!=0, rs2!=0 -> {100,1,rd,rs2,10}.
  - C.SUB/XOR/OR/AND: R-type SUB/XOR/OR/AND, rd==rs1, rd and rs2 both primed -> {100011,rd',op,rs2',01}, with op = 00/01/10/11 respectively.
  - C.LI: ADDI, rs1==0, rd!=0, imm in [-32,31] -> {010,imm[5],rd,imm[4:0],01}.
  - C.ADDI: ADDI, rd==rs1!=0, imm!=0, imm in [-32,31] -> {000,imm[5],rd,imm[4:0],01}.
  - C.SLLI: SLLI, rd==rs1!=0, f7==0, shamt!=0 -> {000,0,rd,shamt[4:0],10}.
  - C.LW: LW, rd and rs1 primed, imm in [0,124], imm[1:0]==0 -> {010,imm[5:3],rs1',imm[2],imm[6],rd',00}.
  - C.SW: SW, rs1 and rs2 primed, same offset rule -> {110,imm[5:3],rs1',imm[2],imm[6],rs2',00}.
  - Everything else, including branches and ENABLE_COMPRESS=0, is a 32-bit passthrough.
- Packing on accept (C = compressed halfword, I = 32-bit word, P = pending halfword):
  - Compressed, no P: P<=C, pend_valid=1, no output.
  - Compressed, P: out_word<={C,P}, pend_valid=0.
  - Uncompressed, no P: out_word<=I.
  - Uncompressed, P: out_word<={I[15:0],P}, P<=I[31:16], pend_valid stays 1. The instruction straddles two words.
  - Loading out_word sets out_valid=1 and out_last=0.
  - compressed_count increments on each compressed accept and saturates at all-ones.
- FSM:
  - RUN: flush=1 -> FLUSH.
  - FLUSH, when out_free:
    - If pend_valid: out_word<={16'h0001 (C.NOP),P}, out_last=1, pend_valid=0.
    - Then -> DRAIN.
  - DRAIN: when out_valid==0, or the current word handshakes this cycle, assert flush_done for one cycle -> RUN.
  - Flush with nothing pending and the output empty: flush_done exactly 2 cycles after the flush pulse.
  - flush while state!=RUN is ignored.
- No combinational path from in_valid to out_valid. Accept-to-out_valid latency is 1 cycle.

Test Plan:
- Packing two compressed: accept 0x00B50533 (add a0,a0,a1), then 0xFFF40413 (addi s0,s0,-1) -> no output after the first; out_word=0x147D952E after the second; compressed_count=2.
- Passthrough: accept 0x123452B7 (lui t0,0x12345) with nothing pending -> out_word=0x123452B7 next cycle; count unchanged.
- Straddle plus flush: accept 0x00B50533, then 0x123452B7 -> out_word=0x52B7952E. Pulse flush -> out_word=0x00011234 with out_last=1; flush_done pulses after that word handshakes.
- LW boundary: 0x00852483 (lw s1,8(a0)) -> compressed 0x4504. 0x08052483 (offset 128) -> uncompressed. 0x00A52483 (offset 10) -> uncompressed.
- Backpressure and ENABLE_COMPRESS=0:
  - Hold out_ready=0 with out_valid=1 -> in_ready=0, and out_word/out_last stay stable for 10 cycles.
  - With ENABLE_COMPRESS=0, 0x00B50533 passes through unchanged.
- Reset mid-operation: leave 0x952E pending, assert reset for 1 cycle -> out_valid=0 and count=0. A following flush emits nothing and gives flush_done 2 cycles later.
